// File: rtl/udp_tx_pkt_fifo_if.sv
// -----------------------------------------------------------------------------
// udp_tx_pkt_fifo_if
// Purpose : 32-bit AXI-Stream bundle used on both sides of the UDP TX packet
//           FIFO. The producer of a stream uses the master modport, the
//           consumer uses the slave modport.
// Signals : tdata  - payload word, byte [31:24] first
//           tkeep  - byte enables (meaningful on the tlast beat)
//           tvalid - word valid
//           tlast  - last word of packet
//           tready - consumer accepts word
// -----------------------------------------------------------------------------
interface udp_tx_pkt_fifo_if;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_tx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// udp_tx_pkt_fifo
// Purpose : Store-and-forward packet buffer for the UDP transmit path. Payload
//           words are held until the whole packet has arrived; only then is
//           the packet offered to the 32->8 serializer together with its byte
//           length. Packets that do not fit in the data memory are dropped
//           whole.
// Ports   : aclk            - clock, rising edge
//           areset          - synchronous active-high reset
//           s_axis          - slave stream from the application
//           m_axis          - master stream to the serializer (tkeep = 1111)
//           m_pkt_len       - byte length of the head packet
//           m_pkt_len_valid - a committed packet is at the head
//           pkt_drop        - one-cycle pulse when a packet is discarded
// -----------------------------------------------------------------------------
module udp_tx_pkt_fifo #(
   parameter int DEPTH_LOG2 = 9,
   parameter int PKTS_LOG2  = 3
) (
   input  logic                     aclk,
   input  logic                     areset,
   udp_tx_pkt_fifo_if.slave         s_axis,
   udp_tx_pkt_fifo_if.master        m_axis,
   output logic [15:0]              m_pkt_len,
   output logic                     m_pkt_len_valid,
   output logic                     pkt_drop
);

   localparam int AW   = DEPTH_LOG2;
   localparam int PW   = PKTS_LOG2;
   localparam int NPKT = 1 << PW;

   localparam logic [AW:0]   PTR_ONE     = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   DEPTH_WORDS = {1'b1, {AW{1'b0}}};
   localparam logic [PW-1:0] IDX_ONE     = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW:0]   CNT_ZERO    = {(PW+1){1'b0}};
   localparam logic [PW:0]   CNT_ONE     = {{PW{1'b0}}, 1'b1};
   localparam logic [PW+1:0] NPKT_OCC    = {2'b01, {PW{1'b0}}};

   // Bytes carried by the last word; unusual enables count as a full word.
   function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
      logic [2:0] n;
      case (keep)
         4'b1000: n = 3'd1;
         4'b1100: n = 3'd2;
         4'b1110: n = 3'd3;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   // Data memory (no reset: contents are only meaningful below wr_commit)
   logic [31:0]   mem_q [0:(1<<AW)-1];

   // Write side
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   wr_commit_q, wr_commit_d;
   logic          ovf_q, ovf_d;
   logic          drop_q, drop_d;
   logic          pend_q, pend_d;          // commit waiting to enter length queue
   logic [15:0]   pend_len_q, pend_len_d;
   logic          s_tready_q, s_tready_d;

   // Length queue and packet accounting
   logic [15:0]   lq_q [NPKT];
   logic [15:0]   lq_d [NPKT];
   logic [PW-1:0] lq_wr_q, lq_wr_d;
   logic [PW-1:0] lq_head_q, lq_head_d;    // packet currently owned by m_axis
   logic [PW-1:0] lq_fetch_q, lq_fetch_d;  // next packet the prefetcher starts
   logic [PW:0]   count_q, count_d;        // committed, not yet popped
   logic [PW:0]   avail_q, avail_d;        // committed, not yet started by prefetch

   // Read side
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]   words_left_q, words_left_d;
   logic [31:0]   m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic [15:0]   len_q, len_d;
   logic          len_valid_q, len_valid_d;

   // Combinational helpers
   logic          beat_s, mem_full_s, mem_we_s;
   logic          push_s, pop_s, can_load_s, fetch_s, start_s;
   logic [15:0]   words_ext_s, head_len_s, head_words_s;
   logic [PW+1:0] occ_s;

   // Next-state logic for both the write and read side
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      wr_commit_d  = wr_commit_q;
      ovf_d        = ovf_q;
      drop_d       = 1'b0;
      pend_d       = 1'b0;
      pend_len_d   = pend_len_q;
      lq_d         = lq_q;
      lq_wr_d      = lq_wr_q;
      lq_head_d    = lq_head_q;
      lq_fetch_d   = lq_fetch_q;
      count_d      = count_q;
      avail_d      = avail_q;
      rd_ptr_d     = rd_ptr_q;
      words_left_d = words_left_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      fetch_s      = 1'b0;
      start_s      = 1'b0;
      mem_we_s     = 1'b0;

      beat_s      = s_axis.tvalid && s_tready_q;
      mem_full_s  = (wr_ptr_q - wr_commit_q + wr_commit_q - rd_ptr_q) == DEPTH_WORDS;
      words_ext_s = {{(15-AW){1'b0}}, (wr_ptr_q - wr_commit_q)};

      // ---- write side: tentative pointer, rewind on overflow ----
      if (beat_s) begin
         if (ovf_q || mem_full_s) begin
            if (s_axis.tlast) begin
               wr_ptr_d = wr_commit_q;
               ovf_d    = 1'b0;
               drop_d   = 1'b1;
            end else begin
               ovf_d    = 1'b1;
            end
         end else begin
            mem_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis.tlast) begin
               wr_commit_d = wr_ptr_q + PTR_ONE;
               pend_d      = 1'b1;
               // words_ext_s is words-1 of this packet
               pend_len_d  = (words_ext_s << 2) + {13'd0, keep_bytes(s_axis.tkeep)};
            end else begin
               pend_d      = 1'b0;
            end
         end
      end else begin
         mem_we_s = 1'b0;
      end

      // ---- length queue push (one cycle after commit) ----
      push_s = pend_q;
      if (push_s) begin
         lq_d[lq_wr_q] = pend_len_q;
         lq_wr_d       = lq_wr_q + IDX_ONE;
      end else begin
         lq_wr_d       = lq_wr_q;
      end

      // ---- output register prefetch ----
      pop_s        = m_valid_q && m_axis.tready && m_last_q;
      can_load_s   = !m_valid_q || m_axis.tready;
      head_len_s   = lq_q[lq_fetch_q];
      head_words_s = (head_len_s + 16'd3) >> 2;
      if (can_load_s) begin
         if (words_left_q != 16'd0) begin
            fetch_s      = 1'b1;
            words_left_d = words_left_q - 16'd1;
            m_last_d     = (words_left_q == 16'd1);
            m_valid_d    = 1'b1;
         end else if (avail_q != CNT_ZERO) begin
            fetch_s      = 1'b1;
            start_s      = 1'b1;
            words_left_d = head_words_s - 16'd1;
            m_last_d     = (head_words_s == 16'd1);
            m_valid_d    = 1'b1;
            lq_fetch_d   = lq_fetch_q + IDX_ONE;
         end else begin
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
         end
      end else begin
         m_valid_d = m_valid_q;
      end

      if (fetch_s) begin
         m_data_d = mem_q[rd_ptr_q[AW-1:0]];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         m_data_d = m_data_q;
      end

      if (pop_s) begin
         lq_head_d = lq_head_q + IDX_ONE;
      end else begin
         lq_head_d = lq_head_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case ({push_s, start_s})
         2'b10:   avail_d = avail_q + CNT_ONE;
         2'b01:   avail_d = avail_q - CNT_ONE;
         default: avail_d = avail_q;
      endcase

      // A commit still in flight already owns a queue slot, so it counts
      // toward occupancy; this keeps the queue from ever overfilling.
      occ_s      = {1'b0, count_d} + {{(PW+1){1'b0}}, pend_d};
      s_tready_d = (occ_s < NPKT_OCC);

      len_valid_d = (count_d != CNT_ZERO);
      if (len_valid_d) begin
         len_d = lq_d[lq_head_d];
      end else begin
         len_d = 16'd0;
      end
   end

   // Payload memory write port
   always_ff @(posedge aclk) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q     <= {(AW+1){1'b0}};
         wr_commit_q  <= {(AW+1){1'b0}};
         ovf_q        <= 1'b0;
         drop_q       <= 1'b0;
         pend_q       <= 1'b0;
         pend_len_q   <= 16'd0;
         s_tready_q   <= 1'b0;
         for (int i = 0; i < NPKT; i++) begin
            lq_q[i] <= 16'd0;
         end
         lq_wr_q      <= {PW{1'b0}};
         lq_head_q    <= {PW{1'b0}};
         lq_fetch_q   <= {PW{1'b0}};
         count_q      <= CNT_ZERO;
         avail_q      <= CNT_ZERO;
         rd_ptr_q     <= {(AW+1){1'b0}};
         words_left_q <= 16'd0;
         m_data_q     <= 32'd0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         len_q        <= 16'd0;
         len_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         wr_commit_q  <= wr_commit_d;
         ovf_q        <= ovf_d;
         drop_q       <= drop_d;
         pend_q       <= pend_d;
         pend_len_q   <= pend_len_d;
         s_tready_q   <= s_tready_d;
         lq_q         <= lq_d;
         lq_wr_q      <= lq_wr_d;
         lq_head_q    <= lq_head_d;
         lq_fetch_q   <= lq_fetch_d;
         count_q      <= count_d;
         avail_q      <= avail_d;
         rd_ptr_q     <= rd_ptr_d;
         words_left_q <= words_left_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         len_q        <= len_d;
         len_valid_q  <= len_valid_d;
      end
   end

   assign s_axis.tready   = s_tready_q;
   assign m_axis.tdata    = m_data_q;
   assign m_axis.tvalid   = m_valid_q;
   assign m_axis.tlast    = m_last_q;
   assign m_axis.tkeep    = 4'b1111;
   assign m_pkt_len       = len_q;
   assign m_pkt_len_valid = len_valid_q;
   assign pkt_drop        = drop_q;

endmodule

// File: tb/tb_udp_tx_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_pkt_fifo
// Purpose : Self-checking bench for udp_tx_pkt_fifo (DEPTH_LOG2=4,
//           PKTS_LOG2=3). Inputs are driven and outputs sampled on the
//           falling clock edge.
// -----------------------------------------------------------------------------
module tb_udp_tx_pkt_fifo;

   logic        aclk;
   logic        areset;
   logic [15:0] m_pkt_len;
   logic        m_pkt_len_valid;
   logic        pkt_drop;

   udp_tx_pkt_fifo_if s_if ();
   udp_tx_pkt_fifo_if m_if ();

   udp_tx_pkt_fifo #(.DEPTH_LOG2(4), .PKTS_LOG2(3)) dut (
      .aclk            (aclk),
      .areset          (areset),
      .s_axis          (s_if),
      .m_axis          (m_if),
      .m_pkt_len       (m_pkt_len),
      .m_pkt_len_valid (m_pkt_len_valid),
      .pkt_drop        (pkt_drop)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_err = 0;
   int drop_seen = 0;
   int valid_seen = 0;

   // Free-running observation of DUT-only outputs
   always @(negedge aclk) begin
      if (pkt_drop)    drop_seen++;
      if (m_if.tvalid) valid_seen++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out", nm);
   endtask

   function automatic logic [31:0] word(input logic [7:0] id, input int i);
      logic [7:0] ib;
      ib = i[7:0];
      return {id, ib, id ^ 8'hC3, ib ^ 8'hA5};
   endfunction

   // One beat; returns on the falling edge after the accepting rising edge
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int guard;
      guard = 0;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      while (!s_if.tready && guard < 300) begin
         @(negedge aclk);
         guard++;
      end
      if (guard >= 300) fail_timeout("s_tready_wait");
      @(negedge aclk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic send_pkt(input int nw, input logic [3:0] keep, input logic [7:0] id);
      for (int i = 0; i < nw; i++) begin
         // non-last beats carry junk tkeep, which must be ignored
         send_beat(word(id, i), (i == nw - 1) ? keep : 4'b0101, (i == nw - 1));
      end
   endtask

   task automatic recv_pkt(input int nw, input logic [7:0] id, input logic [15:0] exp_len);
      int guard;
      m_if.tready = 1'b1;
      for (int i = 0; i < nw; i++) begin
         guard = 0;
         while (!m_if.tvalid && guard < 300) begin
            @(negedge aclk);
            guard++;
         end
         if (guard >= 300) begin
            fail_timeout("m_tvalid_wait");
            return;
         end
         check("rx_data", m_if.tdata, word(id, i));
         check("rx_last", {31'd0, m_if.tlast}, {31'd0, (i == nw - 1)});
         check("rx_len", {16'd0, m_pkt_len}, {16'd0, exp_len});
         check("rx_len_valid", {31'd0, m_pkt_len_valid}, 32'd1);
         @(negedge aclk);
      end
   endtask

   typedef struct {
      int         nwords;
      logic [3:0] keep;
      logic [15:0] exp_len;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int         idx;
      logic       prev_valid, prev_ready, prev_last;
      logic [31:0] prev_data;
      int         d0, v0;

      vecs[0] = '{3,  4'b1100, 16'd10};
      vecs[1] = '{1,  4'b1000, 16'd1};
      vecs[2] = '{1,  4'b1111, 16'd4};
      vecs[3] = '{2,  4'b1110, 16'd7};
      vecs[4] = '{4,  4'b0001, 16'd16};
      vecs[5] = '{16, 4'b1111, 16'd64};
      vecs[6] = '{5,  4'b0000, 16'd20};
      vecs[7] = '{2,  4'b1000, 16'd5};

      s_if.tdata  = 32'd0;
      s_if.tkeep  = 4'd0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b0;
      areset      = 1'b1;

      // ---- reset state ----
      repeat (3) @(negedge aclk);
      check("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
      check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      check("rst_m_tdata", m_if.tdata, 32'd0);
      check("rst_len_valid", {31'd0, m_pkt_len_valid}, 32'd0);
      check("rst_m_tkeep", {28'd0, m_if.tkeep}, 32'd15);
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_s_tready", {31'd0, s_if.tready}, 32'd1);

      // ---- 3-word packet, latency ----
      send_pkt(3, 4'b1100, 8'h11);
      check("lat_n_valid", {31'd0, m_if.tvalid}, 32'd0);
      check("lat_n_len_valid", {31'd0, m_pkt_len_valid}, 32'd0);
      @(negedge aclk);
      check("lat_n1_len_valid", {31'd0, m_pkt_len_valid}, 32'd1);
      check("lat_n1_len", {16'd0, m_pkt_len}, 32'd10);
      check("lat_n1_valid", {31'd0, m_if.tvalid}, 32'd0);
      @(negedge aclk);
      check("lat_n2_valid", {31'd0, m_if.tvalid}, 32'd1);
      recv_pkt(3, 8'h11, 16'd10);
      check("lat_empty_valid", {31'd0, m_if.tvalid}, 32'd0);
      check("lat_empty_len_valid", {31'd0, m_pkt_len_valid}, 32'd0);

      // ---- table of lengths ----
      for (int v = 0; v < 8; v++) begin
         send_pkt(vecs[v].nwords, vecs[v].keep, 8'(8'h30 + v));
         recv_pkt(vecs[v].nwords, 8'(8'h30 + v), vecs[v].exp_len);
      end

      // ---- serializer cadence, 1 ready in 4 ----
      m_if.tready = 1'b0;
      send_pkt(5, 4'b1111, 8'h20);
      idx = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_last  = 1'b0;
      prev_data  = 32'd0;
      for (int c = 0; c < 200 && idx < 5; c++) begin
         @(negedge aclk);
         if (prev_valid && !prev_ready) begin
            check("cad_hold_valid", {31'd0, m_if.tvalid}, 32'd1);
            check("cad_hold_data", m_if.tdata, prev_data);
            check("cad_hold_last", {31'd0, m_if.tlast}, {31'd0, prev_last});
         end
         if (m_if.tvalid) check("cad_len", {16'd0, m_pkt_len}, 32'd20);
         m_if.tready = (c % 4 == 3);
         if (m_if.tvalid && m_if.tready) begin
            check("cad_data", m_if.tdata, word(8'h20, idx));
            check("cad_last", {31'd0, m_if.tlast}, {31'd0, (idx == 4)});
            idx++;
         end
         prev_valid = m_if.tvalid;
         prev_ready = m_if.tready;
         prev_data  = m_if.tdata;
         prev_last  = m_if.tlast;
      end
      check("cad_words", idx, 32'd5);
      @(negedge aclk);
      m_if.tready = 1'b1;

      // ---- oversize packet dropped ----
      repeat (2) @(negedge aclk);
      d0 = drop_seen;
      v0 = valid_seen;
      send_pkt(20, 4'b1111, 8'h40);
      check("drop_pulse_n1", {31'd0, pkt_drop}, 32'd1);
      @(negedge aclk);
      check("drop_pulse_end", {31'd0, pkt_drop}, 32'd0);
      repeat (6) @(negedge aclk);
      check("drop_count", drop_seen - d0, 32'd1);
      check("drop_no_output", valid_seen - v0, 32'd0);
      send_pkt(2, 4'b1111, 8'h41);
      recv_pkt(2, 8'h41, 16'd8);

      // ---- length queue full ----
      m_if.tready = 1'b0;
      for (int p = 0; p < 8; p++) send_pkt(1, 4'b1111, 8'(8'h50 + p));
      check("lq_full_tready", {31'd0, s_if.tready}, 32'd0);
      s_if.tdata  = word(8'h58, 0);
      s_if.tkeep  = 4'b1111;
      s_if.tlast  = 1'b1;
      s_if.tvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge aclk);
         check("lq_full_hold", {31'd0, s_if.tready}, 32'd0);
      end
      fork
         send_beat(word(8'h58, 0), 4'b1111, 1'b1);
         begin
            for (int p = 0; p < 9; p++) recv_pkt(1, 8'(8'h50 + p), 16'd4);
         end
      join
      repeat (4) @(negedge aclk);
      check("lq_drained_valid", {31'd0, m_if.tvalid}, 32'd0);

      // ---- 100 one-word packets streaming ----
      m_if.tready = 1'b1;
      fork
         begin
            for (int p = 0; p < 100; p++) begin
               logic [3:0] kk;
               case (p % 4)
                  0:       kk = 4'b1000;
                  1:       kk = 4'b1100;
                  2:       kk = 4'b1110;
                  default: kk = 4'b1111;
               endcase
               send_pkt(1, kk, 8'(p));
            end
         end
         begin
            for (int p = 0; p < 100; p++) recv_pkt(1, 8'(p), 16'((p % 4) + 1));
         end
      join
      repeat (4) @(negedge aclk);
      check("stream_empty_valid", {31'd0, m_if.tvalid}, 32'd0);
      check("stream_empty_len_valid", {31'd0, m_pkt_len_valid}, 32'd0);

      // ---- reset mid-packet ----
      m_if.tready = 1'b0;
      send_pkt(2, 4'b1111, 8'h60);
      send_beat(word(8'h61, 0), 4'b1111, 1'b0);
      send_beat(word(8'h61, 1), 4'b1111, 1'b0);
      check("prerst_valid", {31'd0, m_if.tvalid}, 32'd1);
      areset = 1'b1;
      @(negedge aclk);
      check("mrst_s_tready", {31'd0, s_if.tready}, 32'd0);
      check("mrst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      check("mrst_m_tlast", {31'd0, m_if.tlast}, 32'd0);
      check("mrst_m_tdata", m_if.tdata, 32'd0);
      check("mrst_len", {16'd0, m_pkt_len}, 32'd0);
      check("mrst_len_valid", {31'd0, m_pkt_len_valid}, 32'd0);
      check("mrst_drop", {31'd0, pkt_drop}, 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      check("mrst_tready_back", {31'd0, s_if.tready}, 32'd1);
      send_pkt(1, 4'b1000, 8'h70);
      recv_pkt(1, 8'h70, 16'd1);
      repeat (4) @(negedge aclk);
      check("mrst_no_stale", {31'd0, m_if.tvalid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
